// File: rtl/codificador_display_mux_pkg.sv
// Shared types and constants for the multiplexed 7-segment display encoder.
package codificador_display_mux_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } estado_t;

    // Active-low segment patterns, bit6..bit0 = a..g
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    localparam logic [6:0] SEG_TABLE [0:9] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    // 10^n, wide enough for n up to 9
    function automatic logic [31:0] pow10(input int n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 0; i < n; i++) r = r * 32'd10;
        return r;
    endfunction

endpackage

// File: rtl/codificador_display_mux_if.sv
// Load/status/display bundle between the display encoder and its user.
interface codificador_display_mux_if #(
    parameter int N_DIGITS = 4,
    parameter int VALUE_W  = 14
);
    logic [VALUE_W-1:0]  valor;
    logic                cargar;
    logic                busy;
    logic                done;
    logic                overflow;
    logic [6:0]          seg;
    logic [N_DIGITS-1:0] an;

    modport master (output valor, cargar, input busy, done, overflow, seg, an);
    modport slave  (input valor, cargar, output busy, done, overflow, seg, an);
endinterface

// File: rtl/codificador_display_mux_dec7seg.sv
// BCD digit to active-low 7-segment pattern; non-decimal codes go dark.
module decodificador_7seg
    import codificador_display_mux_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // table lookup with blank fallback for codes 10..15
    always_comb begin
        seg = SEG_BLANK;
        if (bcd <= 4'd9) seg = SEG_TABLE[bcd];
    end

endmodule

// File: rtl/codificador_display_mux.sv
// Binary-to-BCD converter (double-dabble FSM) feeding a scanned,
// multiplexed 7-segment display with leading-zero blanking and overflow dashes.
module codificador_display_mux
    import codificador_display_mux_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int VALUE_W     = 14,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_LZ    = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    codificador_display_mux_if.slave bus
);

    localparam int BCD_W = 4 * N_DIGITS;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int PS_W  = $clog2(REFRESH_DIV);
    localparam int CNT_W = $clog2(VALUE_W + 1);

    estado_t                  estado;
    logic [VALUE_W-1:0]       bin;
    logic [N_DIGITS-1:0][3:0] bcd, bcd_adj, banco;
    logic [BCD_W:0]           sh;
    logic [CNT_W-1:0]         cnt;
    logic                     ovf_cap, busy_r, done_r, ovf_r;

    logic [PS_W-1:0]          presc;
    logic [IDX_W-1:0]         idx;
    logic [N_DIGITS-1:0]      blank;
    logic [6:0]               seg_dec, seg_r;
    logic [N_DIGITS-1:0]      an_r;

    // add-3 correction on every digit >= 5 before the shift
    always_comb begin
        bcd_adj = bcd;
        for (int k = 0; k < N_DIGITS; k++)
            if (bcd[k] >= 4'd5) bcd_adj[k] = bcd[k] + 4'd3;
    end

    // upper digits beyond N_DIGITS are dropped; overflow shows dashes anyway
    assign sh = {bcd_adj, bin[VALUE_W-1]};

    // converter FSM: capture, shift VALUE_W times, then commit bank atomically
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado  <= IDLE;
            bin     <= '0;
            bcd     <= '0;
            cnt     <= '0;
            ovf_cap <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            ovf_r   <= 1'b0;
            banco   <= '0;
        end else begin
            done_r <= 1'b0;
            case (estado)
                IDLE: begin
                    if (bus.cargar) begin
                        bin     <= bus.valor;
                        bcd     <= '0;
                        cnt     <= '0;
                        ovf_cap <= (32'(bus.valor) >= pow10(N_DIGITS));
                        busy_r  <= 1'b1;
                        estado  <= CONVERT;
                    end
                end
                CONVERT: begin
                    bcd <= sh[BCD_W-1:0];
                    bin <= bin << 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(VALUE_W - 1)) estado <= COMMIT;
                end
                COMMIT: begin
                    banco  <= bcd;
                    ovf_r  <= ovf_cap;
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    estado <= IDLE;
                end
                default: estado <= IDLE;
            endcase
        end
    end

    // free-running scan: prescaler wrap advances the digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PS_W'(REFRESH_DIV - 1)) begin
            presc <= '0;
            idx   <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // leading-zero mask: digit k>0 dark while it and everything above is zero
    always_comb begin
        logic nz;
        nz    = 1'b0;
        blank = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            nz = nz | (banco[k] != 4'd0);
            if (BLANK_LZ != 0 && k != 0 && !nz) blank[k] = 1'b1;
        end
    end

    decodificador_7seg u_dec (
        .bcd (banco[idx]),
        .seg (seg_dec)
    );

    // registered drive of the current slot; overflow overrides blanking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r <= SEG_BLANK;
            an_r  <= '1;
        end else if (ovf_r) begin
            seg_r <= SEG_DASH;
            an_r  <= ~(N_DIGITS'(1) << idx);
        end else if (blank[idx]) begin
            seg_r <= SEG_BLANK;
            an_r  <= '1;
        end else begin
            seg_r <= seg_dec;
            an_r  <= ~(N_DIGITS'(1) << idx);
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.overflow = ovf_r;
    assign bus.seg      = seg_r;
    assign bus.an       = an_r;

endmodule
